// File: rtl/input_sync_debounce.sv
// Purpose : per-channel synchroniser + stability filter + registered rise/fall pulses
// Latency : STAGES+DEBOUNCE edges with the filter built in, STAGES+1 edges without it
// Backpress: none; free-running level path, every output is a flop
//
// Ports:
//    clk    - single clock, all state updates on its rising edge
//    reset  - asynchronous, active-high; clears all state immediately
//    in     - raw asynchronous inputs, WIDTH channels
//    out    - synchronised, filtered level per channel
//    rise   - one-cycle pulse when out[i] goes 0->1
//    fall   - one-cycle pulse when out[i] goes 1->0
//
// Build option: define SYNC_DEBOUNCE_EN to compile in the stability filter.
// Without it out[i] follows the synchroniser output every cycle and DEBOUNCE
// has no effect (same behaviour as DEBOUNCE=1 with the filter built in).

module input_sync_debounce #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 2,
   parameter int               DEBOUNCE  = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 1) begin : g_bad_width
      $error("input_sync_debounce: WIDTH must be >= 1");
   end
   if (STAGES < 2) begin : g_bad_stages
      $error("input_sync_debounce: STAGES must be >= 2");
   end
   if (DEBOUNCE < 1) begin : g_bad_debounce
      $error("input_sync_debounce: DEBOUNCE must be >= 1");
   end

   // ------------------------------------------------------------------
   // Synchroniser chain: stage 0 captures the raw input, the last stage
   // is the metastability-safe level fed to the filter.
   // ------------------------------------------------------------------
   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;
   logic [WIDTH-1:0]             s;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in;
      for (int k = 1; k < STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s = sync_q[STAGES-1];

   // ------------------------------------------------------------------
   // Filtered level and registered edge pulses.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] fall_d;

`ifdef SYNC_DEBOUNCE_EN
   localparam int            CW      = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   logic [WIDTH-1:0][CW-1:0] cnt_q;
   logic [WIDTH-1:0][CW-1:0] cnt_d;

   // cnt[i] counts consecutive cycles s[i] has disagreed with out[i].
   // Any agreement wipes the count, so a partial run is never kept.
   // The accept branch uses >= so the count can never run past CNT_MAX.
   always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= CNT_MAX) begin
            out_d[i] = s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end
`else
   always_comb begin
      out_d = s;
   end
`endif

   // Pulses are computed from the next level so they line up with the
   // cycle in which out changes.
   always_comb begin
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   // ------------------------------------------------------------------
   // State registers. Reset loads RESET_VAL everywhere in the level path,
   // so neither assertion nor release of reset creates an edge pulse.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VAL}};
         out_q  <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync_q <= sync_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

`ifdef SYNC_DEBOUNCE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign out  = out_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_input_sync_debounce.sv
// Bench for input_sync_debounce: two instances with different parameters
// share clock, reset and inputs; a window-based reference model predicts
// every output each cycle, plus directed literal checks.

module tb_input_sync_debounce;

   localparam int         W     = 4;
   localparam int         STG_A = 2;
   localparam int         DEB_A = 4;
   localparam logic [3:0] RV_A  = 4'b0000;
   localparam int         STG_B = 3;
   localparam int         DEB_B = 3;
   localparam logic [3:0] RV_B  = 4'b1010;

`ifdef SYNC_DEBOUNCE_EN
   localparam int DE_A = DEB_A;
   localparam int DE_B = DEB_B;
`else
   localparam int DE_A = 1;
   localparam int DE_B = 1;
`endif

   localparam int LAT_A = STG_A + DE_A;

   logic         clk;
   logic         reset;
   logic [W-1:0] in_v;
   logic [W-1:0] out_a, rise_a, fall_a;
   logic [W-1:0] out_b, rise_b, fall_b;

   int n_cmp = 0;
   int n_bad = 0;

   input_sync_debounce #(.WIDTH(W), .STAGES(STG_A), .DEBOUNCE(DEB_A), .RESET_VAL(RV_A)) u_a (
      .clk(clk), .reset(reset), .in(in_v), .out(out_a), .rise(rise_a), .fall(fall_a));

   input_sync_debounce #(.WIDTH(W), .STAGES(STG_B), .DEBOUNCE(DEB_B), .RESET_VAL(RV_B)) u_b (
      .clk(clk), .reset(reset), .in(in_v), .out(out_b), .rise(rise_b), .fall(fall_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------
   // Reference model. Rule: the synchronised level seen by the filter
   // at edge k is the raw input sampled STG edges earlier (RESET_VAL for
   // the first STG edges after reset). A channel flips at edge k exactly
   // when the last D such samples since reset all differ from its level.
   // ---------------------------------------------------------------
   logic [3:0] in_buf [0:63];
   int         k_edge;
   logic [3:0] m_out_a, m_rise_a, m_fall_a;
   logic [3:0] m_out_b, m_rise_b, m_fall_b;

   function automatic logic [3:0] s_at(int j, int stg, logic [3:0] rv);
      if (j - stg >= 1) return in_buf[(j - stg) % 64];
      return rv;
   endfunction

   function automatic logic [3:0] next_out(int kk, int stg, int d, logic [3:0] rv,
                                           logic [3:0] cur);
      logic [3:0] r;
      logic [3:0] sv;
      bit         all_diff;
      r = cur;
      for (int i = 0; i < 4; i++) begin
         all_diff = (kk >= d);
         if (all_diff) begin
            for (int j = kk - d + 1; j <= kk; j++) begin
               sv = s_at(j, stg, rv);
               if (sv[i] == cur[i]) all_diff = 1'b0;
            end
         end
         if (all_diff) r[i] = ~cur[i];
      end
      return r;
   endfunction

   initial begin
      logic [3:0] no;
      k_edge   = 0;
      m_out_a  = RV_A; m_rise_a = '0; m_fall_a = '0;
      m_out_b  = RV_B; m_rise_b = '0; m_fall_b = '0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            k_edge   = 0;
            m_out_a  = RV_A; m_rise_a = '0; m_fall_a = '0;
            m_out_b  = RV_B; m_rise_b = '0; m_fall_b = '0;
         end else begin
            k_edge++;
            in_buf[k_edge % 64] = in_v;
            no       = next_out(k_edge, STG_A, DE_A, RV_A, m_out_a);
            m_rise_a = no & ~m_out_a;
            m_fall_a = ~no & m_out_a;
            m_out_a  = no;
            no       = next_out(k_edge, STG_B, DE_B, RV_B, m_out_b);
            m_rise_b = no & ~m_out_b;
            m_fall_b = ~no & m_out_b;
            m_out_b  = no;
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         n_cmp++;
         if ({out_a, rise_a, fall_a} !== {m_out_a, m_rise_a, m_fall_a}) begin
            n_bad++;
            $display("FAIL model_a t=%0t: out/rise/fall got %b/%b/%b want %b/%b/%b", $time,
                     out_a, rise_a, fall_a, m_out_a, m_rise_a, m_fall_a);
         end
         n_cmp++;
         if ({out_b, rise_b, fall_b} !== {m_out_b, m_rise_b, m_fall_b}) begin
            n_bad++;
            $display("FAIL model_b t=%0t: out/rise/fall got %b/%b/%b want %b/%b/%b", $time,
                     out_b, rise_b, fall_b, m_out_b, m_rise_b, m_fall_b);
         end
      end
   end

   // Pulse counters used by the directed checks.
   int pr_a [4];
   int pf_a [4];
   int pr_b [4];
   int pf_b [4];

   initial begin
      for (int i = 0; i < 4; i++) begin
         pr_a[i] = 0; pf_a[i] = 0; pr_b[i] = 0; pf_b[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            pr_a[i] += int'(rise_a[i]);
            pf_a[i] += int'(fall_a[i]);
            pr_b[i] += int'(rise_b[i]);
            pf_b[i] += int'(fall_b[i]);
         end
      end
   end

   task automatic clr_pulses();
      for (int i = 0; i < 4; i++) begin
         pr_a[i] = 0; pf_a[i] = 0; pr_b[i] = 0; pf_b[i] = 0;
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int         hold [4];
      int         maxh;
      logic [3:0] nv;

      reset = 1'b1;
      in_v  = 4'hF;

      // Reset held with inputs high: nothing moves.
      cyc(2);
      chk("rst_out_a",  out_a,  RV_A);
      chk("rst_rise_a", rise_a, 4'b0000);
      chk("rst_fall_a", fall_a, 4'b0000);
      chk("rst_out_b",  out_b,  RV_B);
      reset = 1'b0;

      // First acceptance after release.
      cyc(LAT_A - 1);
      chk("rel_out_before", out_a,  4'h0);
      chk("rel_rise_before", rise_a, 4'h0);
      cyc(1);
      chk("rel_out_at",  out_a,  4'hF);
      chk("rel_rise_at", rise_a, 4'hF);
      cyc(1);
      chk("rel_rise_after", rise_a, 4'h0);
      chk("rel_out_after",  out_a,  4'hF);
      cyc(6);
      chk("rel_out_b", out_b, 4'hF);

      // Clean step on channel 0.
      in_v = 4'h0;
      cyc(12);
      clr_pulses();
      in_v = 4'b0001;
      cyc(LAT_A - 1);
      chk("step_out_before", out_a, 4'b0000);
      cyc(1);
      chk("step_out_at",  out_a,  4'b0001);
      chk("step_rise_at", rise_a, 4'b0001);
      cyc(10);
      chk_int("step_rise_cnt", pr_a[0], 1);
      chk_int("step_fall_cnt", pf_a[0], 0);

      // Glitch one cycle too short, then exactly long enough.
      in_v = 4'h0;
      cyc(12);
      clr_pulses();
      in_v = 4'b0010;
      cyc(DE_A - 1);
      in_v = 4'h0;
      cyc(12);
      chk_int("glitch_short_rise", pr_a[1], 0);
      chk_int("glitch_short_fall", pf_a[1], 0);
      clr_pulses();
      in_v = 4'b0010;
      cyc(DE_A);
      in_v = 4'h0;
      cyc(14);
      chk_int("glitch_min_rise", pr_a[1], 1);
      chk_int("glitch_min_fall", pf_a[1], 1);

      // Independent channels changing on the same edge.
      in_v = 4'b1000;
      cyc(12);
      in_v = 4'b0100;
      cyc(LAT_A);
      chk("indep_rise", rise_a, 4'b0100);
      chk("indep_fall", fall_a, 4'b1000);
      chk("indep_out",  out_a,  4'b0100);

      // Asynchronous reset in the middle of a count.
      in_v = 4'h0;
      cyc(12);
      in_v = 4'b0001;
      cyc(STG_A + 2);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_a",  out_a,  RV_A);
      chk("arst_rise_a", rise_a, 4'b0000);
      chk("arst_fall_a", fall_a, 4'b0000);
      chk("arst_out_b",  out_b,  RV_B);
      cyc(2);
      reset = 1'b0;
      cyc(LAT_A - 1);
      chk("arst_rel_before", out_a, 4'b0000);
      cyc(1);
      chk("arst_rel_out",  out_a,  4'b0001);
      chk("arst_rel_rise", rise_a, 4'b0001);

      // Single-cycle input pulse: passes only when the filter length is 1.
      in_v = 4'h0;
      cyc(12);
      clr_pulses();
      in_v = 4'b0001;
      cyc(1);
      in_v = 4'h0;
      cyc(12);
      chk_int("pulse1_rise_a", pr_a[0], (DE_A == 1) ? 1 : 0);
      chk_int("pulse1_rise_b", pr_b[0], (DE_B == 1) ? 1 : 0);
      chk_int("pulse1_fall_b", pf_b[0], (DE_B == 1) ? 1 : 0);

      // Randomised phases: per-channel hold lengths of varying range,
      // with occasional asynchronous resets between clock edges.
      for (int i = 0; i < 4; i++) hold[i] = 1;
      for (int ph = 0; ph < 6; ph++) begin
         maxh = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 5 : 9);
         for (int c = 0; c < 500; c++) begin
            nv = in_v;
            for (int i = 0; i < 4; i++) begin
               hold[i]--;
               if (hold[i] <= 0) begin
                  nv[i]   = ~nv[i];
                  hold[i] = int'($urandom_range(1, maxh));
               end
            end
            in_v = nv;
            if ($urandom_range(0, 249) == 0) begin
               #2 reset = 1'b1;
               #1;
               cyc(1);
               reset = 1'b0;
            end else begin
               cyc(1);
            end
         end
      end

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/input_sync_debounce.md
# input_sync_debounce

Parametrised multi-channel input conditioner that sits between asynchronous board inputs (switches, keys, camera strobes) and the synchronous core logic. Each channel passes through a configurable-depth synchroniser chain for metastability protection. It then passes through a stability filter that only accepts a new level after it has held for a programmable number of cycles. Registered one-cycle rise/fall pulses are also provided per channel, so downstream FSMs need no edge detectors of their own.

## Interface
- WIDTH, 1, number of independent input channels (≥1)
- STAGES, 2, synchroniser flip-flops per channel (≥2)
- DEBOUNCE, 4, consecutive cycles a synchronised level must hold before it is accepted (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into every synchroniser stage and into out on reset

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk
- in  input  WIDTH  raw asynchronous inputs
- out  output  WIDTH  synchronised, filtered level per channel
- rise  output  WIDTH  one-cycle pulse when out[i] goes 0→1
- fall  output  WIDTH  one-cycle pulse when out[i] goes 1→0

## Operation
- Per channel i, fully independent; there is no shared state between channels.
- Synchroniser: shift chain of STAGES flops; s[i] is the last stage.
- Filter state per channel: counter cnt[i], width $clog2(DEBOUNCE+1), plus the out[i] register.
  - s[i] == out[i]: cnt[i] ← 0.
  - s[i] != out[i] and cnt[i] < DEBOUNCE-1: cnt[i] ← cnt[i]+1.
  - s[i] != out[i] and cnt[i] == DEBOUNCE-1: out[i] ← s[i], cnt[i] ← 0.
- Glitch rejection: any return of s[i] to out[i] before acceptance clears cnt[i]. The count restarts from 0; partial counts are never kept.
- Edge outputs are registered:
  - rise[i] ← (next out[i]) & ~out[i]
  - fall[i] ← ~(next out[i]) & out[i]
  - Each asserts in the same cycle out[i] changes and lasts exactly one cycle.
  - rise[i] and fall[i] are never high together.
- Reset (asynchronous, any time, including mid-count): all sync stages and out ← RESET_VAL, cnt ← 0, rise/fall ← 0.
  - No edge pulse is generated by reset assertion or by reset release.
  - After release, filtering restarts from cnt = 0.

## Timing
- Input stable from before rising edge 1 onward: s[i] shows the new level after edge STAGES.
- out[i] and its pulse update after edge STAGES+DEBOUNCE.
  - Defaults (STAGES=2, DEBOUNCE=4): latency is 6 edges.
- Minimum accepted pulse width is DEBOUNCE cycles as seen at s[i]. A level held at s[i] for DEBOUNCE-1 cycles or fewer is discarded.
- Toggling faster than the filter accepts keeps out[i] constant indefinitely.
- The counter saturates at DEBOUNCE-1 by construction and never wraps.
- Every output is a flop output; there are no combinational paths from in to any output.

## Configuration
- SYNC_DEBOUNCE_EN defined: stability filter compiled in, behaving as in Operation.
- SYNC_DEBOUNCE_EN undefined:
  - Filter counters are removed and DEBOUNCE is ignored.
  - out[i] ← s[i] every cycle, giving a fixed latency of STAGES+1 edges.
  - rise/fall still derive from out changes.
  - Behaviour is identical to DEBOUNCE=1 with the macro defined.

## Test plan
- Reset with RESET_VAL=4'b0000, WIDTH=4, defaults: hold reset 2 cycles, in=4'hF during reset -> out=0, rise=fall=0 throughout. After release with in held at 4'hF, out=4'hF and rise=4'hF for one cycle at edge 6 after release.
- Clean step on in[0] 0→1 held 10 cycles -> out[0]=1 after exactly 6 edges; rise[0] pulses one cycle; fall stays 0.
- Glitch: in[1] high for 3 cycles, then low -> out[1] stays 0, no rise/fall. Repeat with 4 cycles high -> out[1] pulses high for 4 cycles, with rise then fall 4 cycles apart.
- Channel independence: in[2] rises and in[3] falls on the same edge (in[3] previously accepted high) -> out[2] rises and out[3] falls on the same edge; rise=4'b0100, fall=4'b1000 for one cycle.
- Async reset mid-count: assert reset between clock edges while cnt[0]=2 -> out, rise, fall clear immediately without a clock edge. After release with in[0] still 1, the full 6-edge latency applies again.
- Macro undefined build, STAGES=3: step on in[0] -> out[0] changes after 4 edges; a 1-cycle input pulse propagates as a 1-cycle out pulse.
